// File: rtl/bcd_cnt_pkg.sv
// Shared types and helpers for the BCD tick counter.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Prescale ratio; zero TICK_HZ yields 0 so the range check trips cleanly
    function automatic int unsigned calcDiv(input int unsigned clkHz, input int unsigned tickHz);
        if (tickHz == 0) begin
            return 0;
        end
        return clkHz / tickHz;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV prescaler producing a registered one-cycle tick pulse.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    input  logic iCLR,
    output logic oTICK
);

    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : gDivCheck
            $error("tick_prescaler: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cntQ;
    logic             tickQ;

    // Count enabled cycles; the tick lands in the cycle after the count leaves its last value
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cntQ  <= '0;
            tickQ <= 1'b0;
        end else if (iCLR) begin
            cntQ  <= '0;
            tickQ <= 1'b0;
        end else if (iEN) begin
            if (cntQ == CNT_LAST) begin
                cntQ  <= '0;
                tickQ <= 1'b1;
            end else begin
                cntQ  <= cntQ + 1'b1;
                tickQ <= 1'b0;
            end
        end else begin
            // Disabled: count frozen, tick forced low
            tickQ <= 1'b0;
        end
    end

    assign oTICK = tickQ;

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit up/down BCD counter stepped by a divided-down tick.
// Define BCD_CNT_LOAD_EN to add the iLOAD / iLOAD_VAL synchronous load path.
module bcd_tick_counter
    import bcd_cnt_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 4,
    parameter int unsigned DIGITS  = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iEN,
    input  logic                  iDIR,
    input  logic                  iCLR,
`ifdef BCD_CNT_LOAD_EN
    input  logic                  iLOAD,
    input  logic [4*DIGITS-1:0]   iLOAD_VAL,
`endif
    output logic [4*DIGITS-1:0]   oBCD,
    output logic                  oTICK,
    output logic                  oCARRY
);

    localparam int unsigned DIV = calcDiv(CLK_HZ, TICK_HZ);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : gDigitsCheck
            $error("bcd_tick_counter: DIGITS must be in 1..8");
        end
    endgenerate

    logic                tickPulse;
    logic                doStep;
    logic                wrap;
    logic [4*DIGITS-1:0] bcdQ;
    logic                carryQ;
    logic [DIGITS-1:0]   atEdge;
    logic [DIGITS-1:0]   lowAll;
    logic [4*DIGITS-1:0] stepBcd;

    tick_prescaler #(
        .DIV(DIV)
    ) uPrescaler (
        .iCLK (iCLK),
        .iRST (iRST),
        .iEN  (iEN),
        .iCLR (iCLR),
        .oTICK(tickPulse)
    );

    // A step happens on the edge that closes a tick cycle while still enabled
    assign doStep = tickPulse & iEN;

    // Digit chain: a digit moves only when every lower digit is about to wrap
    for (genvar i = 0; i < DIGITS; i++) begin : gDigit
        bcd_digit_t cur;
        bcd_digit_t upVal;
        bcd_digit_t dnVal;

        assign cur       = bcdQ[4*i +: 4];
        assign atEdge[i] = iDIR ? (cur == 4'd0) : (cur == BCD_MAX);
        assign upVal     = (cur == BCD_MAX) ? 4'd0 : cur + 4'd1;
        assign dnVal     = (cur == 4'd0) ? BCD_MAX : cur - 4'd1;

        if (i == 0) begin : gLsd
            assign lowAll[i] = 1'b1;
        end else begin : gUpper
            assign lowAll[i] = &atEdge[i-1:0];
        end

        assign stepBcd[4*i +: 4] = !lowAll[i] ? cur : (iDIR ? dnVal : upVal);
    end

    // All digits at their limit means this step rolls the whole count over
    assign wrap = &atEdge;

`ifdef BCD_CNT_LOAD_EN
    logic [4*DIGITS-1:0] loadBcd;

    // Out-of-range load digits saturate at 9
    for (genvar i = 0; i < DIGITS; i++) begin : gLoad
        bcd_digit_t lv;
        assign lv                = iLOAD_VAL[4*i +: 4];
        assign loadBcd[4*i +: 4] = (lv > BCD_MAX) ? BCD_MAX : lv;
    end
`endif

    // Count register with clear > load > step priority; carry flags only a stepped wrap
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bcdQ   <= '0;
            carryQ <= 1'b0;
        end else if (iCLR) begin
            bcdQ   <= '0;
            carryQ <= 1'b0;
`ifdef BCD_CNT_LOAD_EN
        end else if (iLOAD) begin
            bcdQ   <= loadBcd;
            carryQ <= 1'b0;
`endif
        end else if (doStep) begin
            bcdQ   <= stepBcd;
            carryQ <= wrap;
        end else begin
            carryQ <= 1'b0;
        end
    end

    assign oBCD   = bcdQ;
    assign oTICK  = tickPulse;
    assign oCARRY = carryQ;

endmodule

// File: doc/bcd_tick_counter.md
BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 4: count-step rate in Hz.
REQ-003 The block SHALL have parameter DIGITS, default 2, range 1..8: number of BCD digits.
REQ-004 The block SHALL have port iCLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port iRST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port iEN, input, 1 bit: 1 = prescaler and counter run; 0 = both hold.
REQ-007 The block SHALL have port iDIR, input, 1 bit: 0 = count up, 1 = count down.
REQ-008 The block SHALL have port iCLR, input, 1 bit: synchronous clear of the digits and the prescaler.
REQ-009 The block SHALL have port iLOAD, input, 1 bit, present only under BCD_CNT_LOAD_EN: synchronous load strobe.
REQ-010 The block SHALL have port iLOAD_VAL, input, 4*DIGITS bits, present only under BCD_CNT_LOAD_EN: load value, digit 0 in bits [3:0].
REQ-011 The block SHALL have port oBCD, output, 4*DIGITS bits: registered count, digit 0 least significant.
REQ-012 The block SHALL have port oTICK, output, 1 bit: registered one-cycle step pulse.
REQ-013 The block SHALL have port oCARRY, output, 1 bit: registered one-cycle wrap pulse.

Function
REQ-014 The block SHALL compute DIV = CLK_HZ/TICK_HZ (integer); elaboration SHALL fail if DIV < 2.
REQ-015 The prescaler counter SHALL be $clog2(DIV) bits wide, SHALL count 0..DIV-1 while iEN=1, and SHALL return to 0 after DIV-1.
REQ-016 oTICK SHALL be high for exactly one cycle per DIV enabled cycles: high in the cycle after the prescaler leaves DIV-1.
REQ-017 The counter SHALL step on the rising edge that ends a cycle with oTICK=1 and iEN=1; new oBCD is visible 1 cycle later.
REQ-018 An up step SHALL increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit; all-9s SHALL go to all-0s.
REQ-019 A down step SHALL decrement digit 0; a digit at 0 SHALL go to 9 and borrow; all-0s SHALL go to all-9s.
REQ-020 oCARRY SHALL be high for exactly the one cycle in which oBCD first shows a wrapped value (up or down).
REQ-021 Precedence SHALL be iCLR > iLOAD > count step; a suppressed step SHALL be lost, not deferred.
REQ-022 iCLR SHALL set oBCD=0, prescaler=0, oTICK=0 and oCARRY=0 on the next edge, regardless of iEN.
REQ-023 iLOAD SHALL write iLOAD_VAL into oBCD on the next edge, clamp any digit >9 to 9, leave the prescaler untouched, and never assert oCARRY.
REQ-024 A change of iDIR SHALL take effect on the next step only; no glitch or extra step SHALL occur.
REQ-025 With iEN=0, oTICK SHALL be held 0 and all state SHALL freeze.

Reset
REQ-026 While iRST=1, the block SHALL immediately hold oBCD=0, oTICK=0, oCARRY=0 and prescaler=0, independent of iCLK.
REQ-027 After iRST deasserts, the first oTICK SHALL occur DIV enabled cycles later; a reset mid-count SHALL discard the partial prescale.

Configuration
REQ-028 With BCD_CNT_LOAD_EN defined, iLOAD and iLOAD_VAL SHALL exist and REQ-023 SHALL apply.
REQ-029 Without BCD_CNT_LOAD_EN, iLOAD and iLOAD_VAL SHALL be absent, the load path SHALL be removed, and precedence SHALL be iCLR > count step.

Structure
REQ-030 Package bcd_cnt_pkg SHALL hold typedef bcd_digit_t (4 bits), constant BCD_MAX=4'd9, and a DIV-computation function.
REQ-031 Sub-module tick_prescaler (parameter DIV; ports iCLK, iRST, iEN, iCLR, oTICK) SHALL implement REQ-015/016; the digit chain SHALL stay in bcd_tick_counter as a generate loop.

Verification (CLK_HZ=8, TICK_HZ=2 so DIV=4; DIGITS=2)
REQ-032 Test: release reset with iEN=1, iDIR=0 -> oTICK pulses every 4 cycles; oBCD goes 00,01,...,09,10 with no oCARRY.
REQ-033 Test: count up from 99 -> oBCD=00 and oCARRY=1 for one cycle; down from 00 -> oBCD=99 and oCARRY=1.
REQ-034 Test: drop iEN for 10 cycles mid-prescale -> no oTICK; on re-enable, remaining prescale cycles resume and oBCD is unchanged meanwhile.
REQ-035 Test: assert iCLR and iLOAD (iLOAD_VAL=8'h45) on a tick cycle -> oBCD=00, prescaler=0; iLOAD alone with 8'hA7 -> oBCD=97, oCARRY=0.
REQ-036 Test: pulse iRST asynchronously between clock edges at oBCD=37 -> outputs are 0 before the next edge; first tick follows 4 cycles after release.
REQ-037 Test: build without BCD_CNT_LOAD_EN -> elaborates without load ports; REQ-032/033 tests pass unchanged.
